// File: rtl/switch_debouncer_if.sv
// Raw switch/key inputs, debounced outputs and interrupt lines between the
// board-facing debouncer and the memory-mapped switch device.
interface switch_debouncer_if;
  logic [7:0] dip_switch0, dip_switch1, dip_switch2, dip_switch3;
  logic [7:0] dip_switch4, dip_switch5, dip_switch6, dip_switch7;
  logic [7:0] user_key;
  logic       irq_en;
  logic       irq_ack;
  logic [7:0] deb_switch0, deb_switch1, deb_switch2, deb_switch3;
  logic [7:0] deb_switch4, deb_switch5, deb_switch6, deb_switch7;
  logic [7:0] deb_key;
  logic [8:0] change_mask;
  logic       irq;

  modport master (
    output dip_switch0, dip_switch1, dip_switch2, dip_switch3,
           dip_switch4, dip_switch5, dip_switch6, dip_switch7,
           user_key, irq_en, irq_ack,
    input  deb_switch0, deb_switch1, deb_switch2, deb_switch3,
           deb_switch4, deb_switch5, deb_switch6, deb_switch7,
           deb_key, change_mask, irq
  );

  modport slave (
    input  dip_switch0, dip_switch1, dip_switch2, dip_switch3,
           dip_switch4, dip_switch5, dip_switch6, dip_switch7,
           user_key, irq_en, irq_ack,
    output deb_switch0, deb_switch1, deb_switch2, deb_switch3,
           deb_switch4, deb_switch5, deb_switch6, deb_switch7,
           deb_key, change_mask, irq
  );
endinterface

// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop sync + per-group stability counter for eight
// DIP groups and one key group, sticky change mask and level interrupt.

// One 8-bit group: synchroniser, candidate tracking and commit pulse.
module switch_debouncer_grp #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [7:0]  RST_VAL         = 8'hFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] raw,
  output logic [7:0] stable,
  output logic       commit
);
  logic [7:0]       sync1, sync2, cand;
  logic [CNT_W-1:0] cnt;

  // Commit when the candidate has held long enough and differs from stable.
  always_comb begin
    commit = (sync2 != stable) && (sync2 == cand) &&
             (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  // Sync chain and debounce state; reset discards any pending change.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      cand   <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt  <= '0;
        cand <= stable;
      end else if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (commit) begin
        stable <= cand;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module switch_debouncer #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic              CLK,
  input  logic              RST,
  switch_debouncer_if.slave sw
);
  localparam int NUM_GRP = 9;

  logic [NUM_GRP-1:0][7:0] raw, deb;
  logic [NUM_GRP-1:0]      commit_vec;
  logic [NUM_GRP-1:0]      mask;

  assign raw = {sw.user_key,
                sw.dip_switch7, sw.dip_switch6, sw.dip_switch5, sw.dip_switch4,
                sw.dip_switch3, sw.dip_switch2, sw.dip_switch1, sw.dip_switch0};

  // Group 8 (keys) idles low, DIP groups idle high.
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    localparam logic [7:0] RV = (g == NUM_GRP - 1) ? 8'h00 : 8'hFF;
    switch_debouncer_grp #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (RV)
    ) u_grp (
      .CLK   (CLK),
      .RST   (RST),
      .raw   (raw[g]),
      .stable(deb[g]),
      .commit(commit_vec[g])
    );
  end

  // Sticky change flags: a commit on the ack edge survives the clear.
  always_ff @(posedge CLK) begin
    if (!RST) mask <= '0;
    else      mask <= (mask & ~{NUM_GRP{sw.irq_ack}}) | commit_vec;
  end

  assign sw.deb_switch0 = deb[0];
  assign sw.deb_switch1 = deb[1];
  assign sw.deb_switch2 = deb[2];
  assign sw.deb_switch3 = deb[3];
  assign sw.deb_switch4 = deb[4];
  assign sw.deb_switch5 = deb[5];
  assign sw.deb_switch6 = deb[6];
  assign sw.deb_switch7 = deb[7];
  assign sw.deb_key     = deb[8];
  assign sw.change_mask = mask;
  assign sw.irq         = sw.irq_en & (|mask);
endmodule
